// File: rtl/outbuff_pingpong_ctrl_if.sv
// ============================================================================
// Module  : outbuff_pingpong_ctrl_if
// Brief   : Handshake/bus bundle between the PE-array output path, the
//           ping-pong controller and the output-buffer bank array.
//           Optional OUTBUFF_ROW_MASK_EN adds the row_mask input.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface outbuff_pingpong_ctrl_if #(
  parameter int NUM_PE_ROW = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int TILE_CNT_W = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] cfg_tile_len;
  logic [TILE_CNT_W-1:0] cfg_num_tiles;
  logic                  array_valid;
  logic                  drain_ready;
  logic [NUM_PE_ROW-1:0] wEn_even_AH;
  logic [NUM_PE_ROW-1:0] wEn_odd_AH;
  logic [ADDR_WIDTH-1:0] wAddr;
  logic [NUM_PE_ROW-1:0] rEn_even_AH;
  logic [NUM_PE_ROW-1:0] rEn_odd_AH;
  logic [ADDR_WIDTH-1:0] rAddr;
  logic                  drain_valid;
  logic                  drain_sel_odd;
  logic                  busy;
  logic                  done;
  logic                  overflow_err;

`ifdef OUTBUFF_ROW_MASK_EN
  logic [NUM_PE_ROW-1:0] row_mask;

  modport slave (
    input  start, cfg_tile_len, cfg_num_tiles, array_valid, drain_ready, row_mask,
    output wEn_even_AH, wEn_odd_AH, wAddr, rEn_even_AH, rEn_odd_AH, rAddr,
           drain_valid, drain_sel_odd, busy, done, overflow_err
  );
  modport master (
    output start, cfg_tile_len, cfg_num_tiles, array_valid, drain_ready, row_mask,
    input  wEn_even_AH, wEn_odd_AH, wAddr, rEn_even_AH, rEn_odd_AH, rAddr,
           drain_valid, drain_sel_odd, busy, done, overflow_err
  );
`else
  modport slave (
    input  start, cfg_tile_len, cfg_num_tiles, array_valid, drain_ready,
    output wEn_even_AH, wEn_odd_AH, wAddr, rEn_even_AH, rEn_odd_AH, rAddr,
           drain_valid, drain_sel_odd, busy, done, overflow_err
  );
  modport master (
    output start, cfg_tile_len, cfg_num_tiles, array_valid, drain_ready,
    input  wEn_even_AH, wEn_odd_AH, wAddr, rEn_even_AH, rEn_odd_AH, rAddr,
           drain_valid, drain_sel_odd, busy, done, overflow_err
  );
`endif

endinterface

`default_nettype wire

// File: rtl/outbuff_pingpong_ctrl.sv
// ============================================================================
// Module  : outbuff_pingpong_ctrl
// Brief   : Ping-pong fill/drain scheduler for the even/odd output bank sets.
//           Define OUTBUFF_ROW_MASK_EN to gate all enables with a row mask.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module outbuff_pingpong_ctrl #(
  parameter int NUM_PE_ROW = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int TILE_CNT_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  outbuff_pingpong_ctrl_if.slave bus
);

  localparam logic [1:0] c_FS_IDLE     = 2'd0;
  localparam logic [1:0] c_FS_FILL     = 2'd1;
  localparam logic [1:0] c_FS_WAIT     = 2'd2;
  localparam logic       c_DS_IDLE     = 1'b0;
  localparam logic       c_DS_READ     = 1'b1;
  localparam logic [1:0] c_BK_EMPTY    = 2'd0;
  localparam logic [1:0] c_BK_FILLING  = 2'd1;
  localparam logic [1:0] c_BK_FULL     = 2'd2;
  localparam logic [1:0] c_BK_DRAINING = 2'd3;

  logic [1:0]            fill_state_q, fill_state_d;
  logic                  drain_state_q, drain_state_d;
  logic [1:0][1:0]       bank_st_q, bank_st_d;      // [0]=even set, [1]=odd set
  logic                  fill_ptr_q, fill_ptr_d;
  logic                  drain_ptr_q, drain_ptr_d;
  logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
  logic [TILE_CNT_W-1:0] fill_tiles_q, fill_tiles_d;
  logic [TILE_CNT_W-1:0] drain_tiles_q, drain_tiles_d;
  logic [ADDR_WIDTH-1:0] tile_len_q, tile_len_d;
  logic [TILE_CNT_W-1:0] num_tiles_q, num_tiles_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  dvalid_q, dvalid_d;
  logic                  dsel_q, dsel_d;

  logic                  can_fill, wr_fire, fill_last;
  logic                  can_read, rd_fire, drain_last, job_end;
  logic [NUM_PE_ROW-1:0] row_en;

`ifdef OUTBUFF_ROW_MASK_EN
  logic [NUM_PE_ROW-1:0] mask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mask_q <= '0;
    else if (bus.start && !busy_q)
      mask_q <= bus.row_mask;
  end

  assign row_en = mask_q;
`else
  assign row_en = '1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_state_q  <= c_FS_IDLE;
      drain_state_q <= c_DS_IDLE;
      bank_st_q     <= {c_BK_EMPTY, c_BK_EMPTY};
      fill_ptr_q    <= 1'b0;
      drain_ptr_q   <= 1'b0;
      fill_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      fill_tiles_q  <= '0;
      drain_tiles_q <= '0;
      tile_len_q    <= '0;
      num_tiles_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
      dvalid_q      <= 1'b0;
      dsel_q        <= 1'b0;
    end else begin
      fill_state_q  <= fill_state_d;
      drain_state_q <= drain_state_d;
      bank_st_q     <= bank_st_d;
      fill_ptr_q    <= fill_ptr_d;
      drain_ptr_q   <= drain_ptr_d;
      fill_cnt_q    <= fill_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      fill_tiles_q  <= fill_tiles_d;
      drain_tiles_q <= drain_tiles_d;
      tile_len_q    <= tile_len_d;
      num_tiles_q   <= num_tiles_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ovf_q         <= ovf_d;
      dvalid_q      <= dvalid_d;
      dsel_q        <= dsel_d;
    end
  end

  always_comb begin
    fill_state_d  = fill_state_q;
    drain_state_d = drain_state_q;
    bank_st_d     = bank_st_q;
    fill_ptr_d    = fill_ptr_q;
    drain_ptr_d   = drain_ptr_q;
    fill_cnt_d    = fill_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    fill_tiles_d  = fill_tiles_q;
    drain_tiles_d = drain_tiles_q;
    tile_len_d    = tile_len_q;
    num_tiles_d   = num_tiles_q;
    busy_d        = busy_q;
    ovf_d         = ovf_q;

    // Pointers and counters are already in reset state whenever busy is low.
    if (bus.start && !busy_q) begin
      busy_d               = 1'b1;
      tile_len_d           = bus.cfg_tile_len;
      num_tiles_d          = bus.cfg_num_tiles;
      ovf_d                = 1'b0;
      fill_state_d         = c_FS_FILL;
      bank_st_d[fill_ptr_q] = c_BK_FILLING;
    end

    if (busy_q && bus.array_valid && !can_fill)
      ovf_d = 1'b1;

    if (busy_q && fill_state_q == c_FS_WAIT && bank_st_q[fill_ptr_q] == c_BK_EMPTY) begin
      fill_state_d          = c_FS_FILL;
      bank_st_d[fill_ptr_q] = c_BK_FILLING;
    end

    if (wr_fire) begin
      fill_cnt_d = fill_cnt_q + 1'b1;
      if (fill_last) begin
        bank_st_d[fill_ptr_q] = c_BK_FULL;
        fill_ptr_d            = !fill_ptr_q;
        fill_cnt_d            = '0;
        fill_tiles_d          = fill_tiles_q + 1'b1;
        // Registered status of the other set: a bank freed this cycle waits a cycle.
        if (fill_tiles_q == num_tiles_q)
          fill_state_d = c_FS_IDLE;
        else if (bank_st_q[!fill_ptr_q] == c_BK_EMPTY) begin
          fill_state_d           = c_FS_FILL;
          bank_st_d[!fill_ptr_q] = c_BK_FILLING;
        end else
          fill_state_d = c_FS_WAIT;
      end
    end

    if (busy_q && drain_state_q == c_DS_IDLE && bank_st_q[drain_ptr_q] == c_BK_FULL) begin
      drain_state_d          = c_DS_READ;
      bank_st_d[drain_ptr_q] = c_BK_DRAINING;
    end

    if (rd_fire) begin
      drain_cnt_d = drain_cnt_q + 1'b1;
      if (drain_last) begin
        bank_st_d[drain_ptr_q] = c_BK_EMPTY;
        drain_ptr_d            = !drain_ptr_q;
        drain_cnt_d            = '0;
        drain_tiles_d          = drain_tiles_q + 1'b1;
        drain_state_d          = c_DS_IDLE;
      end
    end

    if (job_end) begin
      busy_d        = 1'b0;
      fill_state_d  = c_FS_IDLE;
      drain_state_d = c_DS_IDLE;
      bank_st_d     = {c_BK_EMPTY, c_BK_EMPTY};
      fill_ptr_d    = 1'b0;
      drain_ptr_d   = 1'b0;
      fill_cnt_d    = '0;
      drain_cnt_d   = '0;
      fill_tiles_d  = '0;
      drain_tiles_d = '0;
    end

    dvalid_d = |(bus.rEn_even_AH | bus.rEn_odd_AH);
    dsel_d   = drain_ptr_q;
    done_d   = job_end;
  end

  always_comb begin
    // A bank that just turned EMPTY is written in the same cycle WAIT notices it.
    can_fill   = busy_q && ((fill_state_q == c_FS_FILL) ||
                            (fill_state_q == c_FS_WAIT && bank_st_q[fill_ptr_q] == c_BK_EMPTY));
    wr_fire    = can_fill && bus.array_valid;
    fill_last  = wr_fire && (fill_cnt_q == tile_len_q);
    can_read   = busy_q && ((drain_state_q == c_DS_READ) ||
                            (drain_state_q == c_DS_IDLE && bank_st_q[drain_ptr_q] == c_BK_FULL));
    rd_fire    = can_read && bus.drain_ready;
    drain_last = rd_fire && (drain_cnt_q == tile_len_q);
    job_end    = drain_last && (drain_tiles_q == num_tiles_q);

    bus.wEn_even_AH   = (wr_fire && !fill_ptr_q)  ? row_en : '0;
    bus.wEn_odd_AH    = (wr_fire &&  fill_ptr_q)  ? row_en : '0;
    bus.rEn_even_AH   = (rd_fire && !drain_ptr_q) ? row_en : '0;
    bus.rEn_odd_AH    = (rd_fire &&  drain_ptr_q) ? row_en : '0;
    bus.wAddr         = fill_cnt_q;
    bus.rAddr         = drain_cnt_q;
    bus.drain_valid   = dvalid_q;
    bus.drain_sel_odd = dsel_q;
    bus.busy          = busy_q;
    bus.done          = done_q;
    bus.overflow_err  = ovf_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_outbuff_pingpong_ctrl.sv
// ============================================================================
// Module  : tb_outbuff_pingpong_ctrl
// Brief   : Scoreboard bench for outbuff_pingpong_ctrl (honours OUTBUFF_ROW_MASK_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_outbuff_pingpong_ctrl;

  typedef struct {
    bit odd;
    int addr;
    bit last;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  outbuff_pingpong_ctrl_if #(.NUM_PE_ROW(16), .ADDR_WIDTH(13), .TILE_CNT_W(8)) bus ();

  outbuff_pingpong_ctrl #(.NUM_PE_ROW(16), .ADDR_WIDTH(13), .TILE_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  ev_t  wr_q[$];
  ev_t  rd_q[$];
  bit   prev_rd = 0;
  bit   prev_odd = 0;
  bit   prev_last = 0;
  bit   saw_overlap = 0;
  int   rdy_mode = 1;
  logic [15:0] exp_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    bus.drain_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.drain_ready = 1'b0;
        1:       bus.drain_ready = 1'b1;
        default: bus.drain_ready = !bus.drain_ready;
      endcase
    end
  end

  // Monitor: pops expected writes/reads as the DUT issues them, checks latency.
  always @(negedge clk) begin
    if (!rst) begin
      bit rd_now, odd_now, last_now;
      ev_t e;
      rd_now = 0; odd_now = 0; last_now = 0;
      if (|bus.wEn_even_AH || |bus.wEn_odd_AH) begin
        if (wr_q.size() == 0) chk("unexpected_write", 32'(bus.wAddr), 32'hFFFF_FFFF);
        else begin
          e = wr_q.pop_front();
          chk("wEn_even", 32'(bus.wEn_even_AH), e.odd ? 32'h0 : 32'(exp_en));
          chk("wEn_odd",  32'(bus.wEn_odd_AH),  e.odd ? 32'(exp_en) : 32'h0);
          chk("wAddr",    32'(bus.wAddr),       32'(e.addr));
        end
      end
      if (|bus.rEn_even_AH || |bus.rEn_odd_AH) begin
        chk("read_needs_ready", 32'(bus.drain_ready), 32'h1);
        if (rd_q.size() == 0) chk("unexpected_read", 32'(bus.rAddr), 32'hFFFF_FFFF);
        else begin
          e = rd_q.pop_front();
          chk("rEn_even", 32'(bus.rEn_even_AH), e.odd ? 32'h0 : 32'(exp_en));
          chk("rEn_odd",  32'(bus.rEn_odd_AH),  e.odd ? 32'(exp_en) : 32'h0);
          chk("rAddr",    32'(bus.rAddr),       32'(e.addr));
          rd_now = 1; odd_now = e.odd; last_now = e.last;
        end
      end
      if ((|bus.wEn_even_AH && |bus.rEn_even_AH) || (|bus.wEn_odd_AH && |bus.rEn_odd_AH))
        chk("same_set_wr_rd", 32'h1, 32'h0);
      if (|bus.wEn_odd_AH && |bus.rEn_even_AH) saw_overlap = 1;
      if (bus.drain_valid || prev_rd) begin
        chk("drain_valid", 32'(bus.drain_valid), 32'(prev_rd));
        if (prev_rd) chk("drain_sel_odd", 32'(bus.drain_sel_odd), 32'(prev_odd));
      end
      if (bus.done || prev_last) begin
        chk("done", 32'(bus.done), 32'(prev_last));
        chk("busy_with_done", 32'(bus.busy), 32'h0);
      end
      prev_rd = rd_now; prev_odd = odd_now; prev_last = last_now;
    end
  end

  task automatic push_ev(input bit odd, input int addr, input bit last, input bit with_rd);
    ev_t e;
    e.odd = odd; e.addr = addr; e.last = last;
    wr_q.push_back(e);
    if (with_rd) rd_q.push_back(e);
  endtask

  task automatic push_job(input int len, input int ntiles);
    for (int t = 0; t <= ntiles; t++)
      for (int a = 0; a <= len; a++)
        push_ev((t % 2) == 1, a, (t == ntiles) && (a == len), 1'b1);
  endtask

  task automatic start_job(input int len, input int ntiles);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.cfg_tile_len = 13'(len);
    bus.cfg_num_tiles = 8'(ntiles);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      bus.array_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.array_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    chk("done_within_budget", 32'(seen), 32'h1);
    @(posedge clk); #1;
    chk("busy_after_job", 32'(bus.busy), 32'h0);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_writes_left"}, 32'(wr_q.size()), 32'h0);
    chk({tag, "_reads_left"},  32'(rd_q.size()), 32'h0);
  endtask

  task automatic flush();
    wr_q.delete();
    rd_q.delete();
    prev_rd = 0; prev_odd = 0; prev_last = 0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cfg_tile_len = '0;
    bus.cfg_num_tiles = '0;
    bus.array_valid = 1'b0;
`ifdef OUTBUFF_ROW_MASK_EN
    bus.row_mask = 16'h00FF;
    exp_en = 16'h00FF;
`else
    exp_en = 16'hFFFF;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_wEn_even", 32'(bus.wEn_even_AH), 32'h0);
    chk("rst_wEn_odd",  32'(bus.wEn_odd_AH),  32'h0);
    chk("rst_rEn_even", 32'(bus.rEn_even_AH), 32'h0);
    chk("rst_rEn_odd",  32'(bus.rEn_odd_AH),  32'h0);
    chk("rst_busy",     32'(bus.busy),        32'h0);
    chk("rst_done",     32'(bus.done),        32'h0);
    chk("rst_dvalid",   32'(bus.drain_valid), 32'h0);
    chk("rst_ovf",      32'(bus.overflow_err),32'h0);

    // Single tile of 4 words.
    rdy_mode = 1;
    push_job(3, 0);
    start_job(3, 0);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    feed(4);
    wait_done(50);
    chk_drained("t1");

    // Four tiles of 8 words, continuous input.
    saw_overlap = 0;
    push_job(7, 3);
    start_job(7, 3);
    feed(32);
    wait_done(100);
    chk("t2_overlap", 32'(saw_overlap), 32'h1);
    chk("t2_no_ovf", 32'(bus.overflow_err), 32'h0);
    chk_drained("t2");

    // Back-pressure on the drain side.
    rdy_mode = 2;
    push_job(3, 0);
    start_job(3, 0);
    feed(4);
    wait_done(50);
    chk_drained("t3");

    // Overflow: drain stalled, both sets fill, fifth word dropped.
    rdy_mode = 0;
    push_ev(0, 0, 0, 0); push_ev(0, 1, 0, 0);
    push_ev(1, 0, 0, 0); push_ev(1, 1, 0, 0);
    start_job(1, 3);
    feed(4);
    @(negedge clk);
    chk("t4_ovf_before", 32'(bus.overflow_err), 32'h0);
    @(posedge clk); #1;
    feed(1);
    @(negedge clk);
    chk("t4_ovf_after", 32'(bus.overflow_err), 32'h1);
    chk("t4_busy", 32'(bus.busy), 32'h1);
    @(posedge clk); #1;
    feed(1);
    @(negedge clk);
    chk("t4_ovf_sticky", 32'(bus.overflow_err), 32'h1);
    chk_drained("t4");
    @(posedge clk); #1;
    rst = 1'b1;
    flush();
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset during the second tile fill, then a one-word job.
    rdy_mode = 1;
    push_job(7, 3);
    start_job(7, 3);
    feed(11);
    bus.array_valid = 1'b1;
    #2;
    rst = 1'b1;
    flush();
    #1;
    chk("t5_wEn_even", 32'(bus.wEn_even_AH), 32'h0);
    chk("t5_wEn_odd",  32'(bus.wEn_odd_AH),  32'h0);
    chk("t5_rEn_even", 32'(bus.rEn_even_AH), 32'h0);
    chk("t5_rEn_odd",  32'(bus.rEn_odd_AH),  32'h0);
    chk("t5_busy",     32'(bus.busy),        32'h0);
    bus.array_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    push_job(0, 0);
    start_job(0, 0);
    feed(1);
    wait_done(20);
    chk("t5_ovf", 32'(bus.overflow_err), 32'h0);
    chk_drained("t5");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
